// File: rtl/dmem_arbiter_pkg.sv
// Shared types and limits for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned NUM_CORES_DEF = 4;
    localparam int unsigned NUM_CORES_MIN = 2;
    localparam int unsigned NUM_CORES_MAX = 8;
    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned DATA_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side and memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
);
    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        busy;
    logic [IDX_W-1:0]            grant_idx;

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_ack, core_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               busy, grant_idx
    );

    // Cores plus memory side
    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_ack, core_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               busy, grant_idx
    );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set req at or above base wins.
module rr_picker #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan upward from base with wrap-around, keep the first hit
    always_comb begin
        int unsigned k;
        k     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(base) + i) % N;
            if (!valid && req[IW'(k)]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises per-core data-memory requests onto one memory port.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); default is round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter  int unsigned ADDR_W    = ADDR_W_DEF,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    localparam int unsigned IDX_W     = $clog2(NUM_CORES)
) (
    input  logic            clk,
    input  logic            RESET,
    dmem_arbiter_if.slave   bus
);

    state_t               state;
    logic [IDX_W-1:0]     lat_idx;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 read_strobe;
    logic                 write_strobe;
    logic [NUM_CORES-1:0] ack;
    logic                 busy_r;

    logic [IDX_W-1:0]     base;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDX_W-1:0]     ptr;
    assign base = ptr;
`endif

    rr_picker #(.N(NUM_CORES)) u_picker (
        .req   (bus.core_req),
        .base  (base),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Three-state access sequencer with registered strobes and ack
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            lat_idx      <= '0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            read_strobe  <= 1'b0;
            write_strobe <= 1'b0;
            ack          <= '0;
            busy_r       <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            ptr          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state        <= ACCESS;
                        lat_idx      <= pick_idx;
                        lat_we       <= bus.core_we[pick_idx];
                        lat_addr     <= bus.core_addr[pick_idx*ADDR_W +: ADDR_W];
                        lat_wdata    <= bus.core_wdata[pick_idx*DATA_W +: DATA_W];
                        read_strobe  <= !bus.core_we[pick_idx];
                        write_strobe <= bus.core_we[pick_idx];
                        busy_r       <= 1'b1;
                    end
                end
                ACCESS: begin
                    state        <= DONE;
                    read_strobe  <= 1'b0;
                    write_strobe <= 1'b0;
                    ack          <= NUM_CORES'(1) << lat_idx;
                end
                DONE: begin
                    state  <= IDLE;
                    ack    <= '0;
                    busy_r <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    ptr    <= (lat_idx == IDX_W'(NUM_CORES - 1)) ? '0 : lat_idx + IDX_W'(1);
`endif
                end
                default: begin
                    state        <= IDLE;
                    read_strobe  <= 1'b0;
                    write_strobe <= 1'b0;
                    ack          <= '0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read   = read_strobe;
    assign bus.mem_write  = write_strobe;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    assign bus.core_ack   = ack;
    assign bus.busy       = busy_r;
    assign bus.grant_idx  = lat_idx;

    // Read data passes straight through from memory during a read's ack cycle
    assign bus.core_rdata = (state == DONE && !lat_we) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk;
    logic RESET;

    dmem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, read data valid the cycle after mem_read
    logic [DW-1:0] mem [256];
    bit            loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[16] <= 16'h1234;
            mem[3]  <= 16'h3333;
            loaded  <= 1'b1;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.core_we[c]            = we;
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
        bus.core_req[c]           = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ack"},   32'(bus.core_ack), 32'h0);
        chk({name, "_busy"},  32'(bus.busy), 32'h0);
        chk({name, "_strb"},  32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk({name, "_addr"},  32'(bus.mem_addr), 32'h0);
        chk({name, "_gidx"},  32'(bus.grant_idx), 32'h0);
        chk({name, "_rdata"}, 32'(bus.core_rdata), 32'h0);
    endtask

    // One isolated transaction with exact cycle-by-cycle checks
    task automatic txn(input int c, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
        @(negedge clk);
        drive(c, we, a, d);
        @(negedge clk);                                 // ACCESS
        chk("acc_busy",  32'(bus.busy), 32'h1);
        chk("acc_strb",  32'({bus.mem_read, bus.mem_write}), 32'({!we, we}));
        chk("acc_addr",  32'(bus.mem_addr), 32'(a));
        chk("acc_gidx",  32'(bus.grant_idx), 32'(c));
        chk("acc_ack",   32'(bus.core_ack), 32'h0);
        if (we) chk("acc_wdata", 32'(bus.mem_wdata), 32'(d));
        @(negedge clk);                                 // DONE
        chk("done_ack",   32'(bus.core_ack), 32'(1) << c);
        chk("done_rdata", 32'(bus.core_rdata), 32'(exp_rd));
        chk("done_strb",  32'({bus.mem_read, bus.mem_write}), 32'h0);
        bus.core_req[c] = 1'b0;
        @(negedge clk);                                 // IDLE
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("idle_ack",  32'(bus.core_ack), 32'h0);
    endtask

    // Raise the requests in mask and check the order in which acks arrive
    task automatic served_order(input string name, input logic [NC-1:0] mask,
                                input logic hold, input logic [1:0] exp_ord [4]);
        int served;
        int cyc;
        int last;
        served = 0;
        cyc    = 0;
        last   = 0;
        @(negedge clk);
        for (int k = 0; k < int'(NC); k++)
            if (mask[k]) drive(k, 1'b0, 16'h0010, 16'h0000);
        while (served < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.core_ack != '0) begin
                chk({name, "_order"}, 32'(bus.core_ack), 32'(1) << exp_ord[served]);
                chk({name, "_rdata"}, 32'(bus.core_rdata), 32'h1234);
                if (served > 0) chk({name, "_spacing"}, 32'(cyc - last), 32'd3);
                last = cyc;
                if (!hold || served == 3) bus.core_req = bus.core_req & ~bus.core_ack;
                served++;
            end
        end
        if (served < 4) chk({name, "_timeout"}, 32'(served), 32'd4);
        bus.core_req = '0;
        @(negedge clk);
    endtask

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t          tbl [6];
    logic [1:0]    ord_a [4];
    logic [1:0]    ord_b [4];
    logic [1:0]    ord_h [4];

    initial begin
        tbl[0] = '{1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        tbl[2] = '{2, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        tbl[3] = '{3, 1'b1, 16'h00FF, 16'h5A5A, 16'h0000};
        tbl[4] = '{3, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A};
        tbl[5] = '{1, 1'b0, 16'h0010, 16'h0000, 16'h1234};

        ord_a = '{2'd0, 2'd1, 2'd2, 2'd3};
`ifdef DMEM_ARB_FIXED_PRIO_EN
        ord_b = '{2'd0, 2'd1, 2'd2, 2'd3};
        ord_h = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        ord_b = '{2'd2, 2'd3, 2'd0, 2'd1};
        ord_h = '{2'd3, 2'd0, 2'd3, 2'd0};
`endif

        bus.core_req   = '0;
        bus.core_we    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        RESET = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst_init");
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle_busy", 32'(bus.busy), 32'h0);

        // Pointer starts at 0
        served_order("cont_a", 4'b1111, 1'b0, ord_a);

        for (int i = 0; i < 6; i++)
            txn(tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);

        // Last table grant was core 1, so the pointer now sits at 2
        served_order("cont_b", 4'b1111, 1'b0, ord_b);

        // Cores 0 and 3 keep requesting through their acks
        served_order("hold", 4'b1001, 1'b1, ord_h);

        // Request dropped during ACCESS still completes
        @(negedge clk);
        drive(2, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        bus.core_req[2] = 1'b0;
        @(negedge clk);
        chk("drop_ack",   32'(bus.core_ack), 32'h4);
        chk("drop_rdata", 32'(bus.core_rdata), 32'h1234);
        @(negedge clk);

        // Reset during DONE: everything clears, no ack afterwards
        drive(3, 1'b0, 16'h0010, 16'h0000);
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        #1;
        chk_all_zero("rst_done");
        bus.core_req = '0;
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done_idle", 32'({bus.busy, bus.core_ack}), 32'h0);

        // Reset during a write's ACCESS, before the commit edge
        drive(0, 1'b1, 16'h0003, 16'h00AA);
        @(negedge clk);
        chk("rstw_strobe", 32'(bus.mem_write), 32'h1);
        RESET = 1'b0;
        #1;
        chk_all_zero("rstw");
        bus.core_req = '0;
        @(negedge clk);
        chk("rstw_noack", 32'(bus.core_ack), 32'h0);
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstw_noack2", 32'(bus.core_ack), 32'h0);
        txn(0, 1'b0, 16'h0003, 16'h0000, 16'h3333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
